// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline register chain.
// Stage state encoding and the occupancy-width function.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_st_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One elastic stage: 2-entry skid buffer (SKID=1) or single register.
// Ports: clk, rst, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  if (SKID != 0) begin : g_skid
    stage_st_e        state;
    stage_st_e        state_n;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // ready decodes registered state only, never out_ready
    assign in_ready  = (state != ST_TWO) && !flush;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;

    always_comb begin
      state_n = state;
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) state_n = ST_ONE;
        end
        ST_ONE: begin
          if (in_fire && !out_fire)
            state_n = ST_TWO;
          else if (!in_fire && out_fire)
            state_n = ST_EMPTY;
        end
        ST_TWO: begin
          if (out_fire) state_n = ST_ONE;
        end
        default: state_n = ST_EMPTY;
      endcase
      if (flush) state_n = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= ST_EMPTY;
        main_q <= RESET_VAL;
        skid_q <= RESET_VAL;
      end else begin
        state <= state_n;
        if (state == ST_TWO) begin
          if (out_fire) main_q <= skid_q;
        end else if (in_fire) begin
          // stalled ONE parks the new beat in skid
          if (state == ST_EMPTY || out_fire)
            main_q <= in_data;
          else
            skid_q <= in_data;
        end
      end
    end
  end else begin : g_plain
    logic             valid_q;
    logic [WIDTH-1:0] main_q;

    assign in_ready  = (!valid_q || out_ready) && !flush;
    assign out_valid = valid_q;
    assign out_data  = main_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (in_fire) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Chain of STAGES elastic stages with flush and occupancy tracking.
// Ports: clk, rst, flush, in_*, out_*, occupancy (beats held).
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 1,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [pipe_pkg::clog2(2*STAGES+1)-1:0] occupancy
);

  localparam int OW = clog2(2*STAGES+1);
  localparam logic [OW-1:0] OCC_ONE = 1;

  for (genvar i = 0; i < STAGES; i++) begin : stg
    logic             in_v;
    logic             in_r;
    logic [WIDTH-1:0] in_d;
    logic             out_v;
    logic             out_r;
    logic [WIDTH-1:0] out_d;

    skid_stage #(
      .WIDTH    (WIDTH),
      .SKID     (SKID),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_v),
      .in_ready (in_r),
      .in_data  (in_d),
      .out_valid(out_v),
      .out_ready(out_r),
      .out_data (out_d)
    );

    if (i == 0) begin : g_first
      assign in_v = in_valid;
      assign in_d = in_data;
    end else begin : g_mid
      assign in_v = stg[i-1].out_v;
      assign in_d = stg[i-1].out_d;
    end

    if (i == STAGES - 1) begin : g_last
      assign out_r = out_ready;
    end else begin : g_next
      assign out_r = stg[i+1].in_r;
    end
  end

  assign in_ready  = stg[0].in_r;
  assign out_valid = stg[STAGES-1].out_v;
  assign out_data  = stg[STAGES-1].out_d;

  logic          in_fire;
  logic          out_fire;
  logic [OW-1:0] occ_q;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = occ_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else if (in_fire && !out_fire) begin
      occ_q <= occ_q + OCC_ONE;
    end else if (!in_fire && out_fire) begin
      occ_q <= occ_q - OCC_ONE;
    end
  end

endmodule
